// File: rtl/addsub_serial.sv
// Digit-serial signed adder/subtractor with accumulate mode.
// Consumes DIGIT bits per clock, LSB digit first, and returns a (WIDTH+1)-bit exact result.
module addsub_serial #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             acc_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   result,
    output logic             carry,
    output logic             ovf
);

    localparam int unsigned K     = WIDTH / DIGIT;
    localparam int unsigned CNT_W = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic               cy_q, cy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH:0]     result_q, result_d;
    logic               carry_q, carry_d;
    logic               ovf_q, ovf_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;

    logic [DIGIT-1:0]   dig_a, dig_b, dig_s;
    logic [DIGIT:0]     dig_sum;
    logic               dig_cout, c_top_in, last_dig;

    // One digit of ripple add; the carry into the digit's top bit is recovered from the sum bit.
    always_comb begin
        dig_a    = opa_q[DIGIT-1:0];
        dig_b    = opb_q[DIGIT-1:0];
        dig_sum  = {1'b0, dig_a} + {1'b0, dig_b} + (DIGIT+1)'(cy_q);
        dig_s    = dig_sum[DIGIT-1:0];
        dig_cout = dig_sum[DIGIT];
        c_top_in = dig_s[DIGIT-1] ^ dig_a[DIGIT-1] ^ dig_b[DIGIT-1];
        last_dig = (cnt_q == CNT_W'(K - 1));
    end

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        cy_d        = cy_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        acc_d       = acc_q;
        result_d    = result_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    opa_d      = acc_mode ? acc_q : a;
                    opb_d      = b ^ {WIDTH{sub}};
                    cy_d       = sub;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                opa_d = opa_q >> DIGIT;
                opb_d = opb_q >> DIGIT;
                cy_d  = dig_cout;
                cnt_d = cnt_q + CNT_W'(1);
                sum_d[cnt_q*DIGIT +: DIGIT] = dig_s;
                if (last_dig) begin
                    result_d    = {dig_a[DIGIT-1] ^ dig_b[DIGIT-1] ^ dig_cout, sum_d};
                    carry_d     = dig_cout;
                    ovf_d       = dig_cout ^ c_top_in;
                    acc_d       = sum_d;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            opa_q       <= '0;
            opb_q       <= '0;
            cy_q        <= 1'b0;
            cnt_q       <= '0;
            sum_q       <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            cy_q        <= cy_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign carry     = carry_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_addsub_serial.sv
// Scoreboard bench for addsub_serial over three WIDTH/DIGIT configurations.
// Expected results come from plain integer arithmetic on the signed/unsigned operands.
module tb_addsub_serial;

    localparam int NCFG = 3;

    int checks = 0;
    int errors = 0;
    int n_done = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NCFG; g++) begin : cfg
        localparam int unsigned W = (g == 1) ? 8 : 4;
        localparam int unsigned D = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
        localparam int unsigned K = W / D;

        logic         rst_n = 1'b0;
        logic         in_valid = 1'b0;
        logic         in_ready;
        logic [W-1:0] a = '0;
        logic [W-1:0] b = '0;
        logic         sub = 1'b0;
        logic         acc_mode = 1'b0;
        logic         out_valid;
        logic         out_ready = 1'b0;
        logic [W:0]   result;
        logic         carry;
        logic         ovf;

        addsub_serial #(.WIDTH(W), .DIGIT(D)) dut (
            .clk(clk), .rst_n(rst_n),
            .in_valid(in_valid), .in_ready(in_ready),
            .a(a), .b(b), .sub(sub), .acc_mode(acc_mode),
            .out_valid(out_valid), .out_ready(out_ready),
            .result(result), .carry(carry), .ovf(ovf)
        );

        // Entry layout: {result[W:0], carry, ovf}
        logic [W+2:0] exp_q[$];
        logic [W+2:0] mon_e;
        logic [W-1:0] m_acc = '0;
        int           accepts = 0;
        int           orm = 0;

        function automatic logic [W+2:0] model(input logic [W-1:0] opa, input logic [W-1:0] opb,
                                               input logic s);
            longint sa, sb, ua, ub, r, lim;
            logic   c, o;
            sa  = longint'($signed(opa));
            sb  = longint'($signed(opb));
            ua  = longint'(opa);
            ub  = longint'(opb);
            r   = s ? (sa - sb) : (sa + sb);
            lim = longint'(1) << (W - 1);
            o   = (r > lim - 1) || (r < -lim);
            c   = s ? (ua >= ub) : ((ua + ub) >= (longint'(1) << W));
            return {(W+1)'(r), c, o};
        endfunction

        task automatic chk(input string name, input longint got, input longint want);
            checks++;
            if (got != want) begin
                errors++;
                $display("FAIL cfg%0d %s: got %0d, expected %0d", g, name, got, want);
            end
        endtask

        // Output consumer policy: 0 always ready, 1 random, 2 stalled.
        always @(posedge clk) begin
            #1;
            out_ready = (orm == 0) ? 1'b1 : ((orm == 1) ? 1'($urandom % 2) : 1'b0);
        end

        // Monitor: every result handshake pops one expected entry.
        always @(negedge clk) begin
            if (rst_n && in_valid && in_ready) accepts++;
            if (rst_n && out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL cfg%0d unexpected_output: got result=%b, expected no output", g, result);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({result, carry, ovf} !== mon_e) begin
                        errors++;
                        $display("FAIL cfg%0d result_carry_ovf: got %b/%b/%b, expected %b/%b/%b",
                                 g, result, carry, ovf, mon_e[W+2:2], mon_e[1], mon_e[0]);
                    end
                end
            end
        end

        task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                             input logic is, input logic iam);
            logic [W+2:0] e;
            int t;
            @(posedge clk);
            #1;
            in_valid = 1'b1; a = ia; b = ib; sub = is; acc_mode = iam;
            t = 0;
            @(negedge clk);
            while (!in_ready && t < 300) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) begin
                chk("accept_timeout", 0, 1);
                in_valid = 1'b0;
            end else begin
                @(posedge clk);
                e = model(iam ? m_acc : ia, ib, is);
                exp_q.push_back(e);
                m_acc = e[W+1:2];
                #1;
                in_valid = 1'b0;
                a = W'($urandom); b = W'($urandom);
                sub = 1'($urandom); acc_mode = 1'($urandom);
            end
        endtask

        task automatic wait_idle();
            int t;
            t = 0;
            while ((exp_q.size() != 0 || !in_ready) && t < 1000) begin
                @(negedge clk);
                t++;
            end
            chk("drain_pending", exp_q.size(), 0);
        endtask

        task automatic pulse_reset();
            @(negedge clk);
            rst_n = 1'b0;
            exp_q.delete();
            m_acc = '0;
            @(negedge clk);
            rst_n = 1'b1;
        endtask

        initial begin
            int lat;
            logic [W+2:0] snap;
            int acc0;

            repeat (3) @(negedge clk);
            chk("reset_in_ready", in_ready, 1);
            chk("reset_out_valid", out_valid, 0);
            chk("reset_outputs", {result, carry, ovf}, 0);
            rst_n = 1'b1;

            // Directed vectors and latency
            if (W == 4) begin
                issue(4'b0000, 4'b1011, 1'b0, 1'b0);
                lat = 1;
                while (!out_valid && lat < 50) begin
                    @(posedge clk);
                    lat++;
                    #1;
                end
                chk("latency_edges", lat, K + 1);
                chk("vec0_result", result, 'b11011);
                issue(4'b0010, 4'b1001, 1'b1, 1'b0);
                issue(4'b0111, 4'b0100, 1'b0, 1'b0);
                issue(4'b1111, 4'b0110, 1'b1, 1'b0);
                wait_idle();
                pulse_reset();
                issue(4'b1010, 4'b0011, 1'b0, 1'b1);
                issue(4'b0101, 4'b0100, 1'b0, 1'b1);
                issue(4'b0000, 4'b1000, 1'b1, 1'b1);
                wait_idle();
                chk("acc_ovf_flag", ovf, 1);
                issue(4'b0110, 4'b0000, 1'b0, 1'b1);
                wait_idle();
                chk("acc_final_value", result, 'b11111);
            end else begin
                issue(W'(8'h7f), W'(8'h01), 1'b0, 1'b0);
                lat = 1;
                while (!out_valid && lat < 50) begin
                    @(posedge clk);
                    lat++;
                    #1;
                end
                chk("latency_edges", lat, K + 1);
                chk("max_plus_one", result, 'b010000000);
                issue(W'(8'h80), W'(8'h01), 1'b1, 1'b0);
                wait_idle();
                chk("min_minus_one", result, 'b101111111);
            end

            // Backpressure: outputs hold while stalled, new requests are not accepted
            orm = 2;
            issue(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
            lat = 0;
            while (!out_valid && lat < 50) begin
                @(negedge clk);
                lat++;
            end
            snap = {result, carry, ovf};
            acc0 = accepts;
            repeat (10) begin
                @(posedge clk);
                #1;
                in_valid = 1'($urandom);
                a = W'($urandom);
                @(negedge clk);
                chk("stall_out_valid", out_valid, 1);
                chk("stall_hold", {result, carry, ovf}, snap);
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            chk("stall_accepts", accepts, acc0);
            orm = 0;
            wait_idle();

            // Asynchronous reset one edge after accept
            issue(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
            @(posedge clk);
            #3;
            rst_n = 1'b0;
            exp_q.delete();
            m_acc = '0;
            #1;
            chk("async_rst_in_ready", in_ready, 1);
            chk("async_rst_out_valid", out_valid, 0);
            chk("async_rst_outputs", {result, carry, ovf}, 0);
            @(negedge clk);
            rst_n = 1'b1;
            issue(W'($urandom), W'(0), 1'b0, 1'b1);
            wait_idle();
            chk("acc_after_reset", result, 0);

            // Random regression with input and output gaps
            orm = 1;
            repeat (350) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
            end
            orm = 0;
            wait_idle();
            n_done++;
        end
    end

    initial begin
        int t;
        t = 0;
        while (n_done < NCFG && t < 60000) begin
            @(posedge clk);
            t++;
        end
        if (n_done < NCFG) begin
            checks++;
            errors++;
            $display("FAIL global_timeout: got %0d configs done, expected %0d", n_done, NCFG);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
